// File: rtl/dab_phase_sequencer.sv
// Dual-bridge switching sequencer: dead-time gate generation, signed inter-bridge
// phase shift applied at period boundaries, soft start ramp and latched fault.
module dab_phase_sequencer #(
    parameter int PERIOD   = 1000,
    parameter int DEADTIME = 20,
    parameter int PHI_MAX  = 450,
    parameter int SS_STEP  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CE,
    input  logic        en,
    input  logic        sync,
    input  logic        fault,
    input  logic [13:0] phi_cmd,
    input  logic        phi_valid,
    output logic        phi_ready,
    output logic [13:0] phi_act,
    output logic        Sp1,
    output logic        Sp2,
    output logic        Sp3,
    output logic        Sp4,
    output logic        Ss1,
    output logic        Ss2,
    output logic        Ss3,
    output logic        Ss4,
    output logic        trigger,
    output logic [1:0]  modo
);
    localparam int CW = $clog2(PERIOD);
    localparam logic signed [15:0] P16  = 16'(PERIOD);
    localparam logic signed [15:0] H16  = 16'(PERIOD / 2);
    localparam logic signed [15:0] DT16 = 16'(DEADTIME);
    localparam logic signed [15:0] HD16 = 16'(PERIOD / 2 + DEADTIME);
    localparam logic signed [15:0] PM16 = 16'(PHI_MAX);
    localparam logic signed [15:0] SS16 = 16'(SS_STEP);

    typedef enum logic [2:0] {IDLE, WAIT_SYNC, SOFTSTART, RUN, FAULT} state_t;
    state_t state, nstate;

    logic [CW-1:0]      cnt;
    logic signed [13:0] phi_pend, phi_cur;
    logic               sync_q;
    logic [3:0]         pgate, sgate;
    logic               active, nactive, bnd, xfer, sync_rise, ss_done;
    logic               pa, pb, sa, sb;
    logic signed [15:0] cmd_w, cmd_c, pend_w, act_w, src_w, diff, nxt_ss;
    logic signed [15:0] cnt_w, s_raw, s_w;

    assign active    = (state == SOFTSTART) || (state == RUN);
    assign nactive   = (nstate == SOFTSTART) || (nstate == RUN);
    assign xfer      = phi_valid && phi_ready;
    assign bnd       = CE && active && (cnt == CW'(PERIOD - 1));
    assign sync_rise = sync && !sync_q;

    // src_w is the phase that will be pending after this cycle, so a transfer
    // landing on the boundary cycle takes effect at that same boundary.
    always_comb begin
        cmd_w  = {{2{phi_cmd[13]}}, phi_cmd};
        pend_w = {{2{phi_pend[13]}}, phi_pend};
        act_w  = {{2{phi_cur[13]}}, phi_cur};
        cmd_c  = cmd_w;
        if (cmd_w > PM16)       cmd_c = PM16;
        else if (cmd_w < -PM16) cmd_c = -PM16;
        src_w  = xfer ? cmd_c : pend_w;
        diff   = src_w - act_w;
        nxt_ss = src_w;
        if (diff > SS16)       nxt_ss = act_w + SS16;
        else if (diff < -SS16) nxt_ss = act_w - SS16;
        ss_done = (nxt_ss == src_w);
        cnt_w  = 16'(cnt);
        s_raw  = cnt_w - act_w;
        s_w    = s_raw;
        if (s_raw < 16'sd0)   s_w = s_raw + P16;
        else if (s_raw >= P16) s_w = s_raw - P16;
        pa = (cnt_w >= DT16) && (cnt_w < H16);
        pb = (cnt_w >= HD16) && (cnt_w < P16);
        sa = (s_w >= DT16) && (s_w < H16);
        sb = (s_w >= HD16) && (s_w < P16);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate    = state;
        phi_ready = active;
        modo      = 2'b00;
        if (fault) nstate = FAULT;
        else if (CE) begin
            case (state)
                IDLE:      if (en) nstate = WAIT_SYNC;
                WAIT_SYNC: if (!en) nstate = IDLE; else if (sync_rise) nstate = SOFTSTART;
                SOFTSTART: if (!en) nstate = IDLE; else if (bnd && ss_done) nstate = RUN;
                RUN:       if (!en) nstate = IDLE;
                FAULT:     if (!en) nstate = IDLE;
                default:   nstate = IDLE;
            endcase
        end
        case (state)
            SOFTSTART: modo = 2'b01;
            RUN:       modo = 2'b10;
            FAULT:     modo = 2'b11;
            default:   modo = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            phi_pend <= '0;
            phi_cur  <= '0;
            sync_q   <= 1'b0;
            trigger  <= 1'b0;
            pgate    <= '0;
            sgate    <= '0;
        end else begin
            if (CE) sync_q <= sync;
            if (xfer) phi_pend <= cmd_c[13:0];
            if (!(active && nactive)) cnt <= '0;
            else if (CE) cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
            if (state == WAIT_SYNC && nstate == SOFTSTART) phi_cur <= '0;
            else if (bnd && nactive) phi_cur <= (state == RUN) ? src_w[13:0] : nxt_ss[13:0];
            trigger <= CE && active && nactive && (cnt == '0);
            // Fault blanks the bridges immediately, even with CE low.
            if (fault) begin
                pgate <= '0;
                sgate <= '0;
            end else if (CE) begin
                pgate <= (active && nactive) ? {pa, pb, pb, pa} : 4'b0;
                sgate <= (active && nactive) ? {sa, sb, sb, sa} : 4'b0;
            end
        end
    end

    assign phi_act = phi_cur;
    assign {Sp1, Sp2, Sp3, Sp4} = pgate;
    assign {Ss1, Ss2, Ss3, Ss4} = sgate;
endmodule

// File: tb/tb_dab_phase_sequencer.sv
// Scoreboard bench for dab_phase_sequencer: expected trigger records and gate
// edge offsets are queued by the stimulus and consumed by a monitor.
module tb_dab_phase_sequencer;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, sync = 1'b0, fault = 1'b0;
    logic        phi_valid = 1'b0;
    logic [13:0] phi_cmd = '0;
    logic        ce_lvl = 1'b1, ce_t = 1'b0, ce_tog = 1'b0;
    logic        CE;
    logic        phi_ready, trigger;
    logic [13:0] phi_act;
    logic        Sp1, Sp2, Sp3, Sp4, Ss1, Ss2, Ss3, Ss4;
    logic [1:0]  modo;

    assign CE = ce_tog ? ce_t : ce_lvl;
    always #5 clk = ~clk;

    dab_phase_sequencer dut (
        .clk(clk), .rst(rst), .CE(CE), .en(en), .sync(sync), .fault(fault),
        .phi_cmd(phi_cmd), .phi_valid(phi_valid), .phi_ready(phi_ready), .phi_act(phi_act),
        .Sp1(Sp1), .Sp2(Sp2), .Sp3(Sp3), .Sp4(Sp4),
        .Ss1(Ss1), .Ss2(Ss2), .Ss3(Ss3), .Ss4(Ss4),
        .trigger(trigger), .modo(modo)
    );

    typedef struct { int modo; int phi; int gap; } trig_t;
    typedef struct { int lvl; int off; } edge_t;
    trig_t tq[$];
    edge_t pq[$], sq[$];
    int    nchk = 0, npass = 0, viol = 0, since = 0;
    bit    arm = 1'b0, mon_on = 1'b0;
    logic  sp1_p = 1'b0, ss1_p = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        nchk++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic int gates();
        return int'({Sp1, Sp2, Sp3, Sp4, Ss1, Ss2, Ss3, Ss4});
    endfunction

    initial forever begin
        @(negedge clk);
        ce_t = ~ce_t;
    end

    // Monitor: trigger pulses pop trigger records; while armed, Sp1/Ss1
    // edges are checked against offsets counted from the trigger sample.
    initial begin : mon
        trig_t t;
        edge_t e;
        forever begin
            @(negedge clk);
            since++;
            if (trigger) begin
                if (tq.size() > 0) begin
                    t = tq.pop_front();
                    chk("trig_modo", int'(modo), t.modo);
                    chk("trig_phi", int'($signed(phi_act)), t.phi);
                    if (t.gap != 0) chk("trig_gap", since, t.gap);
                end
                since = 0;
                if (arm) begin
                    mon_on = 1'b1;
                    arm    = 1'b0;
                end
            end
            if (mon_on) begin
                if (Sp1 !== sp1_p) begin
                    if (pq.size() > 0) begin
                        e = pq.pop_front();
                        chk("sp1_level", int'(Sp1), e.lvl);
                        chk("sp1_offset", since, e.off);
                    end else chk("sp1_extra_edge_offset", since, -1);
                end
                if (Ss1 !== ss1_p) begin
                    if (sq.size() > 0) begin
                        e = sq.pop_front();
                        chk("ss1_level", int'(Ss1), e.lvl);
                        chk("ss1_offset", since, e.off);
                    end else chk("ss1_extra_edge_offset", since, -1);
                end
                if (pq.size() == 0 && sq.size() == 0) mon_on = 1'b0;
            end
            sp1_p = Sp1;
            ss1_p = Ss1;
            if ((Sp1 && Sp2) || (Sp3 && Sp4) || (Ss1 && Ss2) || (Ss3 && Ss4) ||
                (Sp1 != Sp4) || (Sp2 != Sp3) || (Ss1 != Ss4) || (Ss2 != Ss3)) viol++;
        end
    end

    task automatic wait_drain(input int maxc, input string nm);
        int n = 0;
        while ((tq.size() + pq.size() + sq.size() != 0 || mon_on || arm) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) tmo(nm);
        @(negedge clk);
    endtask

    task automatic wait_trig(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trigger && n < 5000);
        if (!trigger) tmo(nm);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_modo", int'(modo), 0);
        chk("rst_gates", gates(), 0);
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_ready", int'(phi_ready), 0);
        chk("rst_phi_act", int'($signed(phi_act)), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_without_en", int'(modo), 0);

        // soft start from sync at 700 ns with +100 held valid
        en = 1'b1; phi_cmd = 14'd100; phi_valid = 1'b1;
        while ($time < 700) @(negedge clk);
        chk("wait_sync_modo", int'(modo), 0);
        chk("wait_sync_ready", int'(phi_ready), 0);
        for (int k = 0; k <= 20; k++)
            tq.push_back(trig_t'{(k == 20) ? 2 : 1, 5 * k, (k == 0) ? 0 : 1000});
        sync = 1'b1;
        wait_drain(22000, "softstart");
        chk("run_modo", int'(modo), 2);
        chk("run_ready", int'(phi_ready), 1);

        // RUN at +100: Sp1 high cnt 20..499, Ss1 high cnt 120..599
        tq.push_back(trig_t'{2, 100, 1000});
        pq.push_back(edge_t'{1, 20});  pq.push_back(edge_t'{0, 500});
        sq.push_back(edge_t'{1, 120}); sq.push_back(edge_t'{0, 600});
        arm = 1'b1;
        wait_drain(3000, "run_edges");

        // -600 clamps to -450; Ss1 high for cnt 570..49 (wrapping)
        phi_cmd = -14'sd600;
        tq.push_back(trig_t'{2, -450, 1000});
        pq.push_back(edge_t'{1, 20});  pq.push_back(edge_t'{0, 500});
        sq.push_back(edge_t'{1, 0});   sq.push_back(edge_t'{0, 50});
        sq.push_back(edge_t'{1, 570});
        arm = 1'b1;
        wait_drain(3000, "clamp_edges");

        // CE alternating: everything stretches by two
        ce_tog = 1'b1;
        wait_trig("ce_toggle_trigger");
        @(negedge clk);
        tq.push_back(trig_t'{2, -450, 2000});
        pq.push_back(edge_t'{1, 40});  pq.push_back(edge_t'{0, 1000});
        sq.push_back(edge_t'{0, 100}); sq.push_back(edge_t'{1, 1140});
        arm = 1'b1;
        wait_drain(6000, "ce_toggle");
        ce_lvl = 1'b1;
        ce_tog = 1'b0;

        // fault while CE low
        wait_trig("fault_trigger");
        repeat (100) @(negedge clk);
        chk("run_sp1_high", int'(Sp1), 1);
        ce_lvl = 1'b0; fault = 1'b1;
        @(negedge clk);
        chk("fault_gates", gates(), 0);
        chk("fault_modo", int'(modo), 3);
        chk("fault_ready", int'(phi_ready), 0);
        fault = 1'b0; ce_lvl = 1'b1;
        repeat (5) @(negedge clk);
        chk("fault_hold_with_en", int'(modo), 3);
        en = 1'b0;
        @(negedge clk);
        chk("fault_exit", int'(modo), 0);

        // restart with zero command: one soft-start period then RUN
        phi_cmd = 14'd0; sync = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        tq.push_back(trig_t'{1, 0, 0});
        tq.push_back(trig_t'{2, 0, 1000});
        sync = 1'b1;
        wait_drain(3000, "restart");
        repeat (100) @(negedge clk);
        chk("run2_sp1_high", int'(Sp1), 1);

        // asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("async_rst_gates", gates(), 0);
        chk("async_rst_trigger", int'(trigger), 0);
        chk("async_rst_ready", int'(phi_ready), 0);
        chk("async_rst_modo", int'(modo), 0);
        chk("async_rst_phi_act", int'($signed(phi_act)), 0);
        en = 1'b0; sync = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", int'(modo), 0);
        chk("post_rst_ready", int'(phi_ready), 0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_wait_sync", int'(modo), 0);
        chk("post_rst_wait_ready", int'(phi_ready), 0);

        chk("deadtime_invariant_violations", viol, 0);
        chk("scoreboard_leftover", tq.size() + pq.size() + sq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/dab_phase_sequencer.md
Name: dab_phase_sequencer

Overview:
- Switching-period sequencer for the dual-bridge converter: generates the primary (Sp1..Sp4) and secondary (Ss1..Ss4) gate signals with dead time and a signed phase shift between bridges.
- Accepts phase-shift commands from the current controller over a valid/ready handshake and applies them only at period boundaries.
- Issues the per-period ADC trigger and reports the operating mode.
- Sits between the control-law block and the gate-driver pins.

Parameters:
PERIOD, 1000, clock counts per switching period (even; 100 kHz at 100 MHz clk)
DEADTIME, 20, counts both devices of a leg are held off after each transition
PHI_MAX, 450, max |phase shift| in counts (< PERIOD/2 - DEADTIME)
SS_STEP, 5, max phase change per period during soft start

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low; one clock domain only
CE  in  1  clock enable; counter and FSM advance only when 1
en  in  1  converter enable from supervisor
sync  in  1  external synchronisation; rising edge starts switching
fault  in  1  synchronous fault (overcurrent/overvoltage), level-sensitive
phi_cmd  in  14  signed two's-complement phase command in counts (+ = secondary lags)
phi_valid  in  1  phi_cmd valid
phi_ready  out  1  sequencer can accept phi_cmd
phi_act  out  14  signed phase currently applied
Sp1, Sp2, Sp3, Sp4  out  1 each  primary bridge gates
Ss1, Ss2, Ss3, Ss4  out  1 each  secondary bridge gates
trigger  out  1  one-cycle ADC sample pulse
modo  out  2  00 IDLE/WAIT_SYNC, 01 SOFTSTART, 10 RUN, 11 FAULT

Behaviour:
- Reset (rst=0): state IDLE; cnt=0; phi_pend=0; phi_act=0; all gates 0; trigger=0; phi_ready=0; modo=00. No CE qualification on reset.
- FSM states: IDLE, WAIT_SYNC, SOFTSTART, RUN, FAULT. Transitions occur only on cycles with CE=1, except fault entry.
  - IDLE -> WAIT_SYNC when en=1.
  - WAIT_SYNC -> SOFTSTART on sync rising edge, detected with a registered copy of sync. cnt=0 and phi_act=0 on entry.
  - WAIT_SYNC/SOFTSTART/RUN -> IDLE when en=0. Gates go 0 the next cycle.
  - SOFTSTART -> RUN at a period boundary where phi_act == phi_pend after the update.
  - Any state -> FAULT when fault=1, regardless of CE. Gates 0 the next cycle. FAULT has priority over en and sync.
  - FAULT -> IDLE only when fault=0 and en=0.
- Counter: in SOFTSTART/RUN, cnt increments 0..PERIOD-1 and wraps when CE=1. It holds when CE=0. In other states it is forced to 0. Boundary = CE=1 and cnt==PERIOD-1.
- Handshake:
  - phi_ready=1 in SOFTSTART and RUN, 0 otherwise.
  - A transfer occurs on a cycle with phi_valid=1 and phi_ready=1.
  - phi_cmd is clamped to [-PHI_MAX, +PHI_MAX] and stored in phi_pend; the last transfer before a boundary wins.
  - A transfer on the boundary cycle is applied at that boundary.
- Phase update at boundary:
  - RUN: phi_act <= phi_pend.
  - SOFTSTART: phi_act moves toward phi_pend by min(|diff|, SS_STEP).
- Gate generation (registered, one cycle after cnt; H=PERIOD/2):
  - Sp1=Sp4 = (DEADTIME <= cnt < H).
  - Sp2=Sp3 = (H+DEADTIME <= cnt < PERIOD).
  - s = (cnt - phi_act) mod PERIOD, computed in 16-bit signed with a +PERIOD correction when negative.
  - Ss1=Ss4 = (DEADTIME <= s < H).
  - Ss2=Ss3 = (H+DEADTIME <= s < PERIOD).
  - All gates are 0 outside SOFTSTART/RUN.
  - Invariant: Sp1&Sp2, Sp3&Sp4, Ss1&Ss2 and Ss3&Ss4 are never 1 in the same cycle.
- trigger: one-cycle pulse the cycle after cnt==0 && CE=1 in SOFTSTART/RUN (mid-dead-time sampling of the primary).
- CE=0 mid-period: all outputs hold their values and trigger=0.

Test Plan:
- rst low mid-RUN, async to clk -> all gates, trigger and phi_ready are 0 within the same cycle and modo=00. After release, stays IDLE until en=1.
- en=1, sync rises at 700 ns, phi_cmd=+100 held valid (defaults) -> modo 01. phi_act steps 5,10,...,100 over 20 periods, then modo=10. Trigger pulses every 1000 cycles.
- RUN with phi_act=100 -> Sp1 high for cnt 20..499, Ss1 high for cnt 120..599. Dead-time invariant holds every cycle.
- phi_cmd=-600 accepted in RUN -> clamped to -450, applied at the next wrap. Ss1 rises at cnt (20-450) mod 1000 = 570.
- fault=1 with CE=0 during RUN -> gates 0 next cycle, modo=11. Deasserting fault alone stays in FAULT; fault=0 and en=0 -> IDLE.
- CE toggled 1/0 every cycle -> period doubles to 2000 clk, gate widths double, no glitches.
